// File: rtl/spi_rx_pkg.sv
// Shared types and constants for the SPI pixel receiver: FSM states,
// host command bytes and the default image size.
package spi_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    PIX_R,
    PIX_G,
    PIX_B,
    TOT,
    STATUS,
    DROP
  } rxState_t;

  localparam logic [7:0] CMD_PIX  = 8'hA0;
  localparam logic [7:0] CMD_TOT  = 8'hB0;
  localparam logic [7:0] CMD_STAT = 8'hC0;

  localparam int PIX_PER_IMG_DEF = 384000;

endpackage

// File: rtl/spi_sync.sv
// Pin synchronizers for the SPI slave plus edge detection on the synchronized
// SCLK and CS_N; edges stay masked until the chains have refilled after reset.
module spi_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic iCLK_50,
  input  logic iRST_N,
  input  logic iSPI_SCLK,
  input  logic iSPI_MOSI,
  input  logic iSPI_CS_N,
  output logic mosiBit,
  output logic csHigh,
  output logic sclkRise,
  output logic sclkFall,
  output logic csFall,
  output logic csRise
);

  logic [SYNC_STAGES-1:0] sclkChain;
  logic [SYNC_STAGES-1:0] mosiChain;
  logic [SYNC_STAGES-1:0] csChain;
  logic                   sclkPrev;
  logic                   csPrev;
  logic [SYNC_STAGES:0]   armChain;
  logic                   sclkNow;
  logic                   armed;

  always_ff @(posedge iCLK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      sclkChain <= '0;
      mosiChain <= '0;
      csChain   <= '1;
      sclkPrev  <= 1'b0;
      csPrev    <= 1'b1;
      armChain  <= '0;
    end else begin
      sclkChain <= (sclkChain << 1) | SYNC_STAGES'(iSPI_SCLK);
      mosiChain <= (mosiChain << 1) | SYNC_STAGES'(iSPI_MOSI);
      csChain   <= (csChain << 1) | SYNC_STAGES'(iSPI_CS_N);
      sclkPrev  <= sclkNow;
      csPrev    <= csHigh;
      armChain  <= {armChain[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // The reset values of the chains are not pin history, so an edge against
  // them (e.g. CS_N already low when reset releases) must not be reported.
  assign armed    = armChain[SYNC_STAGES];
  assign sclkNow  = sclkChain[SYNC_STAGES-1];
  assign mosiBit  = mosiChain[SYNC_STAGES-1];
  assign csHigh   = csChain[SYNC_STAGES-1];

  assign sclkRise = armed &  sclkNow & ~sclkPrev;
  assign sclkFall = armed & ~sclkNow &  sclkPrev;
  assign csFall   = armed & ~csHigh  &  csPrev;
  assign csRise   = armed &  csHigh  & ~csPrev;

endmodule

// File: rtl/spi_pixel_rx.sv
// SPI mode-0 slave that assembles {R,G,B} pixels from the R-Pi, tracks the
// announced image total and pixel count, and answers a one-byte status query.
module spi_pixel_rx
  import spi_rx_pkg::*;
#(
  parameter int PIX_PER_IMG = PIX_PER_IMG_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic        iCLK_50,
  input  logic        iRST_N,
  input  logic        iSPI_SCLK,
  input  logic        iSPI_MOSI,
  input  logic        iSPI_CS_N,
  output logic        oSPI_MISO,
  input  logic        iImage_Loaded,
  output logic [23:0] oPix_Data,
  output logic        oTrigger,
  output logic [7:0]  oImg_Tot,
  output logic [31:0] oPix_Count,
  output logic        oErr
);

  localparam logic [31:0] PIX_PER_IMG_U = 32'(PIX_PER_IMG);

  // Pixel budget wraps modulo 2^32, matching the host's 32-bit view.
  function automatic logic [31:0] pixLimit(input logic [7:0] tot);
    return {24'd0, tot} * PIX_PER_IMG_U;
  endfunction

  function automatic logic pixAllowed(input logic [7:0] tot, input logic [31:0] cnt);
    return (tot != 8'd0) && (cnt < pixLimit(tot));
  endfunction

  function automatic logic [7:0] statusWord(input logic loaded, input logic err,
                                            input logic [7:0] tot);
    return {loaded, err, (tot == 8'd0), 5'b0};
  endfunction

  logic       mosiBit;
  logic       csHigh;
  logic       sclkRise;
  logic       sclkFall;
  logic       csFall;
  logic       csRise;

  logic [2:0] bitCnt;
  logic [7:0] shiftIn;
  logic [7:0] rxByte;
  logic       byteDone;

  rxState_t   state;
  rxState_t   stateNxt;

  logic [7:0] redByte;
  logic [7:0] grnByte;
  logic [7:0] statShift;

  logic       cmdBad;
  logic       statEnter;
  logic       pixDone;
  logic       pixOk;
  logic       abortPix;

  spi_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) uSync (
    .iCLK_50  (iCLK_50),
    .iRST_N   (iRST_N),
    .iSPI_SCLK(iSPI_SCLK),
    .iSPI_MOSI(iSPI_MOSI),
    .iSPI_CS_N(iSPI_CS_N),
    .mosiBit  (mosiBit),
    .csHigh   (csHigh),
    .sclkRise (sclkRise),
    .sclkFall (sclkFall),
    .csFall   (csFall),
    .csRise   (csRise)
  );

  // The completed byte includes the bit being sampled right now, so decode
  // happens on the same cycle as the eighth rise rather than one later.
  assign rxByte   = {shiftIn[6:0], mosiBit};
  assign byteDone = sclkRise & ~csHigh & (bitCnt == 3'd7);

  always_ff @(posedge iCLK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      bitCnt  <= 3'd0;
      shiftIn <= 8'd0;
    end else if (csHigh) begin
      bitCnt  <= 3'd0;
      shiftIn <= 8'd0;
    end else if (sclkRise) begin
      bitCnt  <= bitCnt + 3'd1;
      shiftIn <= rxByte;
    end
  end

  always_ff @(posedge iCLK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      state <= IDLE;
    end else begin
      state <= stateNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    if (csHigh) begin
      stateNxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (csFall) stateNxt = CMD;
        end
        CMD: begin
          if (byteDone) begin
            if (rxByte == CMD_PIX) begin
              stateNxt = PIX_R;
            end else if (rxByte == CMD_TOT) begin
              stateNxt = TOT;
            end else if (rxByte == CMD_STAT) begin
              stateNxt = STATUS;
            end else begin
              stateNxt = DROP;
            end
          end
        end
        PIX_R:  if (byteDone) stateNxt = PIX_G;
        PIX_G:  if (byteDone) stateNxt = PIX_B;
        PIX_B:  if (byteDone) stateNxt = PIX_R;
        TOT:    if (byteDone) stateNxt = DROP;
        STATUS: if (byteDone) stateNxt = DROP;
        DROP:   stateNxt = DROP;
        default: stateNxt = IDLE;
      endcase
    end
  end

  assign cmdBad    = (state == CMD) & byteDone & (rxByte != CMD_PIX) &
                     (rxByte != CMD_TOT) & (rxByte != CMD_STAT);
  assign statEnter = (state == CMD) & byteDone & (rxByte == CMD_STAT);
  assign pixDone   = (state == PIX_B) & byteDone;
  assign pixOk     = pixAllowed(oImg_Tot, oPix_Count);
  // State and bit count still hold their pre-deselect values on this cycle.
  assign abortPix  = csRise & ((state == PIX_G) | (state == PIX_B) | (bitCnt != 3'd0));

  always_ff @(posedge iCLK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      redByte    <= 8'd0;
      grnByte    <= 8'd0;
      oPix_Data  <= 24'd0;
      oTrigger   <= 1'b0;
      oPix_Count <= 32'd0;
      oImg_Tot   <= 8'd0;
      oErr       <= 1'b0;
    end else begin
      oTrigger <= 1'b0;
      if ((state == PIX_R) && byteDone) redByte <= rxByte;
      if ((state == PIX_G) && byteDone) grnByte <= rxByte;
      if (pixDone && pixOk) begin
        oPix_Data  <= {redByte, grnByte, rxByte};
        oTrigger   <= 1'b1;
        oPix_Count <= oPix_Count + 32'd1;
      end
      if ((state == TOT) && byteDone) oImg_Tot <= rxByte;
      if (cmdBad || (pixDone && !pixOk) || abortPix) oErr <= 1'b1;
    end
  end

  // Mode 0: the master samples on SCLK rise, so each status bit is put out
  // on the preceding fall, starting with the fall right after the command.
  always_ff @(posedge iCLK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      statShift <= 8'd0;
      oSPI_MISO <= 1'b0;
    end else begin
      if (statEnter) begin
        statShift <= statusWord(iImage_Loaded, oErr, oImg_Tot);
      end else if ((state == STATUS) && sclkFall) begin
        statShift <= {statShift[6:0], 1'b0};
      end
      if (state != STATUS) begin
        oSPI_MISO <= 1'b0;
      end else if (sclkFall) begin
        oSPI_MISO <= statShift[7];
      end
    end
  end

endmodule

// File: tb/tb_spi_pixel_rx.sv
// Scoreboard bench for spi_pixel_rx: frames are driven at pin level, expected
// pixels are queued as they are sent and matched against each trigger.
module tb_spi_pixel_rx;

  localparam int PPI  = 4;
  localparam int SS   = 2;
  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic        csN = 1'b1;
  logic        imgLoaded = 1'b0;
  logic        miso;
  logic [23:0] pixData;
  logic        trig;
  logic [7:0]  imgTot;
  logic [31:0] pixCount;
  logic        err;

  int nChecks = 0;
  int nPass   = 0;

  logic [23:0] expQ[$];
  logic [7:0]  txQ[$];
  logic [7:0]  rxQ[$];

  int   sinceRise = 0;
  logic sclkSeen  = 1'b0;
  logic prevTrig  = 1'b0;

  always #10 clk = ~clk;

  spi_pixel_rx #(
    .PIX_PER_IMG(PPI),
    .SYNC_STAGES(SS)
  ) dut (
    .iCLK_50      (clk),
    .iRST_N       (rstN),
    .iSPI_SCLK    (sclk),
    .iSPI_MOSI    (mosi),
    .iSPI_CS_N    (csN),
    .oSPI_MISO    (miso),
    .iImage_Loaded(imgLoaded),
    .oPix_Data    (pixData),
    .oTrigger     (trig),
    .oImg_Tot     (imgTot),
    .oPix_Count   (pixCount),
    .oErr         (err)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %h, want %h", tag, got, exp);
  endtask

  // Clock cycles since the pin-level SCLK rise, for the trigger latency bound.
  always @(posedge clk) begin
    sinceRise <= (sclk && !sclkSeen) ? 1 : sinceRise + 1;
    sclkSeen  <= sclk;
  end

  always @(negedge clk) begin
    if (rstN && trig) begin
      checkVal("trigWidth", 32'(prevTrig), 32'd0);
      checkVal("trigLatency", 32'(sinceRise <= SS + 2), 32'd1);
      checkVal("trigPending", 32'(expQ.size() != 0), 32'd1);
      if (expQ.size() != 0) checkVal("pixData", 32'(pixData), 32'(expQ.pop_front()));
    end
    prevTrig = trig;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spiByte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      waitClk(HALF);
      rx[i] = miso;
      sclk = 1'b1;
      waitClk(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic frame();
    logic [7:0] r;
    rxQ.delete();
    csN = 1'b0;
    waitClk(HALF);
    foreach (txQ[k]) begin
      spiByte(txQ[k], r);
      rxQ.push_back(r);
    end
    waitClk(HALF);
    csN = 1'b1;
    waitClk(4 * HALF);
  endtask

  task automatic doReset();
    rstN = 1'b0;
    waitClk(3);
    rstN = 1'b1;
    waitClk(6);
  endtask

  initial begin
    logic [7:0] r;

    // Reset state
    waitClk(3);
    checkVal("rstPix", 32'(pixData), 32'h0);
    checkVal("rstTrig", 32'(trig), 32'h0);
    checkVal("rstTot", 32'(imgTot), 32'h0);
    checkVal("rstCount", pixCount, 32'h0);
    checkVal("rstErr", 32'(err), 32'h0);
    checkVal("rstMiso", 32'(miso), 32'h0);
    rstN = 1'b1;
    waitClk(6);

    // Two images announced, two pixels streamed
    txQ = '{8'hB0, 8'h02};
    frame();
    expQ.push_back(24'h112233);
    expQ.push_back(24'h445566);
    txQ = '{8'hA0, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    frame();
    checkVal("t36Tot", 32'(imgTot), 32'd2);
    checkVal("t36Count", pixCount, 32'd2);
    checkVal("t36Err", 32'(err), 32'd0);
    checkVal("t36Drain", 32'(expQ.size()), 32'd0);

    // Status query, then an unknown command with trailing bytes
    imgLoaded = 1'b1;
    txQ = '{8'hC0, 8'h00};
    frame();
    checkVal("t40MisoCmd", 32'(rxQ[0]), 32'h00);
    checkVal("t40Status", 32'(rxQ[1]), 32'h80);
    checkVal("t40ErrPre", 32'(err), 32'd0);
    txQ = '{8'h55, 8'hA0, 8'h11, 8'h22, 8'h33};
    frame();
    checkVal("t40Err", 32'(err), 32'd1);
    checkVal("t40Count", pixCount, 32'd2);

    // Pixel with no images announced
    doReset();
    txQ = '{8'hA0, 8'h11, 8'h22, 8'h33};
    frame();
    checkVal("t37Err", 32'(err), 32'd1);
    checkVal("t37Count", pixCount, 32'd0);

    // Budget of PPI pixels, five sent
    doReset();
    txQ = '{8'hB0, 8'h01};
    frame();
    txQ = '{8'hA0};
    for (int p = 0; p < 5; p++) begin
      logic [23:0] px;
      px = 24'h102030 + 24'(p) * 24'h010101;
      if (p < PPI) expQ.push_back(px);
      txQ.push_back(px[23:16]);
      txQ.push_back(px[15:8]);
      txQ.push_back(px[7:0]);
    end
    frame();
    checkVal("t38Count", pixCount, 32'd4);
    checkVal("t38Err", 32'(err), 32'd1);
    checkVal("t38Drain", 32'(expQ.size()), 32'd0);

    // Partial pixel aborted by deselect, then a clean pixel
    doReset();
    txQ = '{8'hB0, 8'h01};
    frame();
    txQ = '{8'hA0, 8'h11, 8'h22};
    frame();
    checkVal("t39ErrAbort", 32'(err), 32'd1);
    checkVal("t39CountAbort", pixCount, 32'd0);
    expQ.push_back(24'hAABBCC);
    txQ = '{8'hA0, 8'hAA, 8'hBB, 8'hCC};
    frame();
    checkVal("t39Count", pixCount, 32'd1);
    checkVal("t39Pix", 32'(pixData), 32'hAABBCC);

    // Reset mid-pixel, bytes with CS_N still low ignored, then a clean burst
    csN = 1'b0;
    waitClk(HALF);
    spiByte(8'hA0, r);
    spiByte(8'h11, r);
    spiByte(8'h22, r);
    for (int b = 0; b < 4; b++) begin
      mosi = 1'b1;
      waitClk(HALF);
      sclk = 1'b1;
      waitClk(HALF);
      sclk = 1'b0;
    end
    rstN = 1'b0;
    #1;
    checkVal("t41Pix", 32'(pixData), 32'h0);
    checkVal("t41Trig", 32'(trig), 32'h0);
    checkVal("t41Tot", 32'(imgTot), 32'h0);
    checkVal("t41Count", pixCount, 32'h0);
    checkVal("t41Err", 32'(err), 32'h0);
    checkVal("t41Miso", 32'(miso), 32'h0);
    waitClk(2);
    rstN = 1'b1;
    waitClk(6);
    spiByte(8'hB0, r);
    spiByte(8'h05, r);
    waitClk(HALF);
    csN = 1'b1;
    waitClk(4 * HALF);
    checkVal("t41NoDecode", 32'(imgTot), 32'h0);
    txQ = '{8'hB0, 8'h01};
    frame();
    expQ.push_back(24'h123456);
    txQ = '{8'hA0, 8'h12, 8'h34, 8'h56};
    frame();
    checkVal("t41Count", pixCount, 32'd1);
    checkVal("t41ErrAfter", 32'(err), 32'd0);
    checkVal("t41PixAfter", 32'(pixData), 32'h123456);

    checkVal("finalDrain", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
